md_ctrl: RTL and testbench
==========================

Name: md_ctrl

Overview:
- Sequencer for the HI/LO multiply/divide resource in the pipelined MIPS core.
- Sits in the E stage. Accepts one mult/div/mthi/mtlo operation per issue and models the multi-cycle latency with a counter FSM.
- Owns the architectural HI/LO registers and raises busy so the hazard unit can stall later md instructions.

Parameters:
- MUL_LAT, 5, cycles busy is held for MULT/MULTU (and MADD/MSUB when the optional feature is built in); legal range ≥1.
- DIV_LAT, 10, cycles busy is held for DIV/DIVU; legal range ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  issue strobe from the E stage, one cycle per instruction.
- op  in  4  md operation code (encodings in the package).
- srcA  in  32  rs operand, already forwarded.
- srcB  in  32  rt operand, already forwarded.
- busy  out  1  registered; high while a mult/div is in flight.
- HI  out  32  architectural HI register.
- LO  out  32  architectural LO register.

Behaviour:
- Reset (asynchronous, while reset=0): state=IDLE, cnt=0, busy=0, HI=0, LO=0, staging registers=0.
- States:
  - IDLE→RUN on start with a MULT, MULTU, DIV or DIVU op.
  - RUN→IDLE when cnt reaches 1 at a clock edge.
- Issue at cycle T, IDLE, start=1, op in {MULT, MULTU, DIV, DIVU}:
  - Result is computed combinationally from srcA/srcB and latched into hi_stage/lo_stage at the T edge.
  - cnt is loaded with MUL_LAT or DIV_LAT.
  - busy=1 from cycle T+1 through T+LAT inclusive.
- Each RUN cycle decrements cnt. At the edge ending cycle T+LAT:
  - HI←hi_stage, LO←lo_stage, busy←0.
  - New values are visible in cycle T+LAT+1.
- Arithmetic:
  - MULT: signed 32×32→64; MULTU: unsigned. HI=upper 32 bits, LO=lower 32 bits.
  - DIV: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend. DIVU: unsigned.
  - 0x80000000 / 0xFFFFFFFF (signed) → LO=0x80000000, HI=0.
  - Divide by zero: the op still takes DIV_LAT cycles and busy behaves normally; HI/LO are left unchanged at completion.
- MTHI/MTLO in IDLE: the target register is written at the same edge (visible at T+1). No busy, no state change.
- start with op=MD_NONE or an undefined code: ignored.
- start while busy=1 (any op): ignored. The hazard unit guarantees this never happens (it stalls on start&isMD | busy); the bench checks that HI/LO and cnt are unaffected.
- Completion edge coinciding with a new start: the start is ignored, because busy is still 1 in that cycle.
- Reset asserted mid-RUN: the in-flight op is aborted, HI/LO are cleared and busy drops immediately (asynchronous).
- HI/LO read path: consumers see HI/LO directly. An mfhi/mflo in the same cycle as an mthi/mtlo is resolved by the hazard unit's stall, not forwarded here.

Optional Feature:
- Macro: MD_MADD_EN.
- Defined:
  - Ops MADD, MADDU, MSUB, MSUBU are accepted.
  - Staging = {HI,LO} ± product, computed with the current HI/LO at the issue edge.
  - Latency MUL_LAT, same busy/commit rules as MULT.
- Undefined: these four codes are treated as undefined, so start is ignored.

Decomposition:
- Package md_pkg holds:
  - op encodings: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6, MD_MADD=7, MD_MADDU=8, MD_MSUB=9, MD_MSUBU=10;
  - state enum IDLE/RUN;
  - default latencies.
- One natural sub-module, md_alu: purely combinational, computing the 64-bit {hi,lo} result from op, srcA, srcB and the current HI/LO. md_ctrl keeps only the FSM, counter and registers.

Test Plan:
- MULT: srcA=0xFFFFFFFE (−2), srcB=3 at T → busy=1 for T+1..T+5; HI=0xFFFFFFFF, LO=0xFFFFFFFA at T+6.
- MULTU: same operands → HI=0x00000002, LO=0xFFFFFFFA after 5 busy cycles.
- DIV: 0xFFFFFFF9 (−7) / 2 → busy for 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIV by 0 → HI/LO unchanged after 10 cycles.
- MTHI srcA=0x1234 → HI=0x1234 next cycle, busy stays 0. A start=1 MULT pulse during a running DIV is ignored and the DIV result commits unaltered.
- Reset low at cycle 3 of a DIV → busy=0, HI=LO=0 immediately. After release, a MULT 6×7 gives LO=42 after 5 cycles.
- (MD_MADD_EN) HI=0, LO=0xFFFFFFFF, then MADDU 1×1 → HI=1, LO=0.

Source files
------------

// File: rtl/md_pkg.sv
// Shared op encodings, FSM state type and latency defaults for the HI/LO md unit.
// Optional build macro MD_MADD_EN widens the accepted op set to MADD/MADDU/MSUB/MSUBU.
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MADDU = 4'd8,
    MD_MSUB  = 4'd9,
    MD_MSUBU = 4'd10
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  localparam int MD_MUL_LAT_DEF = 5;
  localparam int MD_DIV_LAT_DEF = 10;

  // Ops that occupy the unit for MUL_LAT cycles.
  function automatic logic md_is_mul(input logic [3:0] op);
    logic r;
    r = (op == MD_MULT) || (op == MD_MULTU);
`ifdef MD_MADD_EN
    r = r || (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`endif
    return r;
  endfunction

  function automatic logic md_is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_alu.sv
// Combinational HI/LO result generator: multiply, divide and (with MD_MADD_EN) accumulate.
// res_vld is low only for a divide by zero, telling the sequencer not to commit.
module md_alu
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res,
  output logic        res_vld
);

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic               sgn_div;
  logic               a_neg;
  logic               b_neg;
  logic [31:0]        mag_a;
  logic [31:0]        mag_b;
  logic [31:0]        div_b;
  logic [31:0]        quo_u;
  logic [31:0]        rem_u;
  logic [31:0]        quo;
  logic [31:0]        rem;

  assign prod_s = $signed({{32{srcA[31]}}, srcA}) * $signed({{32{srcB[31]}}, srcB});
  assign prod_u = {32'd0, srcA} * {32'd0, srcB};

  // Signed divide is done on magnitudes so INT_MIN / -1 falls out as 0x80000000 rem 0.
  assign sgn_div = (op == MD_DIV);
  assign a_neg   = sgn_div & srcA[31];
  assign b_neg   = sgn_div & srcB[31];
  assign mag_a   = a_neg ? (32'd0 - srcA) : srcA;
  assign mag_b   = b_neg ? (32'd0 - srcB) : srcB;
  assign div_b   = (mag_b == 32'd0) ? 32'd1 : mag_b;
  assign quo_u   = mag_a / div_b;
  assign rem_u   = mag_a % div_b;
  assign quo     = (a_neg ^ b_neg) ? (32'd0 - quo_u) : quo_u;
  assign rem     = a_neg ? (32'd0 - rem_u) : rem_u;

  always_comb begin
    res     = {hi, lo};
    res_vld = 1'b1;
    case (op)
      MD_MULT:  res = prod_s;
      MD_MULTU: res = prod_u;
      MD_DIV, MD_DIVU: begin
        if (srcB == 32'd0) res_vld = 1'b0;
        else               res     = {rem, quo};
      end
`ifdef MD_MADD_EN
      MD_MADD:  res = {hi, lo} + prod_s;
      MD_MADDU: res = {hi, lo} + prod_u;
      MD_MSUB:  res = {hi, lo} - prod_s;
      MD_MSUBU: res = {hi, lo} - prod_u;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// E-stage sequencer for the HI/LO multiply/divide resource: latency counter FSM, busy, HI/LO.
// Build with MD_MADD_EN to accept MADD/MADDU/MSUB/MSUBU.
module md_ctrl
  import md_pkg::*;
#(
  parameter int MUL_LAT = MD_MUL_LAT_DEF,
  parameter int DIV_LAT = MD_DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  md_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        wr_q, wr_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_stage_q, hi_stage_d;
  logic [31:0] lo_stage_q, lo_stage_d;

  logic [63:0] alu_res;
  logic        alu_vld;

  md_alu u_alu (
    .op      (op),
    .srcA    (srcA),
    .srcB    (srcB),
    .hi      (hi_q),
    .lo      (lo_q),
    .res     (alu_res),
    .res_vld (alu_vld)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    wr_d       = wr_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    hi_stage_d = hi_stage_q;
    lo_stage_d = lo_stage_q;
    case (state_q)
      IDLE: begin
        if (start && (md_is_mul(op) || md_is_div(op))) begin
          state_d    = RUN;
          cnt_d      = md_is_div(op) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
          busy_d     = 1'b1;
          wr_d       = alu_vld;
          hi_stage_d = alu_res[63:32];
          lo_stage_d = alu_res[31:0];
        end else if (start && (op == MD_MTHI)) begin
          hi_d = srcA;
        end else if (start && (op == MD_MTLO)) begin
          lo_d = srcA;
        end
      end
      RUN: begin
        // Any start seen here is dropped; the hazard unit should have stalled it.
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          if (wr_q) begin
            hi_d = hi_stage_q;
            lo_d = lo_stage_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      wr_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      hi_stage_q <= '0;
      lo_stage_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      wr_q       <= wr_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      hi_stage_q <= hi_stage_d;
      lo_stage_q <= lo_stage_d;
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Directed scoreboard bench for md_ctrl: latency, arithmetic, ignored starts, async reset.
module tb_md_ctrl;
  import md_pkg::*;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] srcA = 32'd0;
  logic [31:0] srcB = 32'd0;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];

  md_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .srcA  (srcA),
    .srcB  (srcB),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one long op; optionally raise a stray MULTU start during busy cycle index inj.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [63:0] exp, input int inj, input string tag);
    logic [63:0] e;
    @(negedge clk);
    start = 1'b1; op = o; srcA = a; srcB = b;
    sb.push_back(exp);
    @(negedge clk);
    for (int i = 0; i < lat; i++) begin
      if (i == inj) begin
        start = 1'b1; op = MD_MULTU; srcA = 32'd5; srcB = 32'd5;
      end else begin
        start = 1'b0;
      end
      chk({tag, " busy"}, {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, " busy_done"}, {31'd0, busy}, 32'd0);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard: observed empty expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, " HI"}, HI, e[63:32]);
      chk({tag, " LO"}, LO, e[31:0]);
    end
  endtask

  task automatic move_to(input logic [3:0] o, input logic [31:0] a, input string tag,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    @(negedge clk);
    start = 1'b1; op = o; srcA = a; srcB = 32'd0;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " HI"}, HI, exp_hi);
    chk({tag, " LO"}, LO, exp_lo);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;

    repeat (2) @(negedge clk);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst HI", HI, 32'd0);
    chk("rst LO", LO, 32'd0);
    reset = 1'b1;

    run_op(MD_MULT,  32'hFFFFFFFE, 32'd3, MUL_LAT, {32'hFFFFFFFF, 32'hFFFFFFFA}, -1, "mult");
    run_op(MD_MULTU, 32'hFFFFFFFE, 32'd3, MUL_LAT, {32'h00000002, 32'hFFFFFFFA}, -1, "multu");
    run_op(MD_DIV,   32'hFFFFFFF9, 32'd2, DIV_LAT, {32'hFFFFFFFF, 32'hFFFFFFFD}, -1, "div");
    run_op(MD_DIV,   32'd1234,     32'd0, DIV_LAT, {32'hFFFFFFFF, 32'hFFFFFFFD}, -1, "div0");
    run_op(MD_DIVU,  32'd100,      32'd7, DIV_LAT, {32'd2, 32'd14}, -1, "divu");
    run_op(MD_DIV,   32'h80000000, 32'hFFFFFFFF, DIV_LAT, {32'd0, 32'h80000000}, -1, "divovf");

    move_to(MD_MTHI, 32'h00001234, "mthi", 32'h00001234, 32'h80000000);
    move_to(MD_MTLO, 32'h00005678, "mtlo", 32'h00001234, 32'h00005678);
    move_to(MD_NONE, 32'hDEADBEEF, "none", 32'h00001234, 32'h00005678);
    move_to(4'd15,   32'hDEADBEEF, "undef", 32'h00001234, 32'h00005678);
`ifndef MD_MADD_EN
    move_to(MD_MADDU, 32'hDEADBEEF, "madd_off", 32'h00001234, 32'h00005678);
`endif

    // Stray start mid-DIV, then a stray start on the completion cycle of a MULT.
    run_op(MD_DIV,  32'hFFFFFFEC, 32'd3, DIV_LAT, {32'hFFFFFFFE, 32'hFFFFFFFA}, 2, "div_stray");
    run_op(MD_MULT, 32'h00010000, 32'h00010000, MUL_LAT, {32'd1, 32'd0}, MUL_LAT - 1, "mult_edge");
    @(negedge clk);
    chk("mult_edge idle busy", {31'd0, busy}, 32'd0);
    chk("mult_edge idle LO", LO, 32'd0);

    // Asynchronous reset during cycle T+3 of a DIV.
    @(negedge clk);
    start = 1'b1; op = MD_DIV; srcA = 32'd77; srcB = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst busy", {31'd0, busy}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst busy", {31'd0, busy}, 32'd0);
    chk("mid_rst HI", HI, 32'd0);
    chk("mid_rst LO", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op(MD_MULT, 32'd6, 32'd7, MUL_LAT, {32'd0, 32'd42}, -1, "mult67");

    for (int k = 0; k < 3; k++) begin
      ra = $urandom;
      rb = $urandom;
      run_op(MD_MULTU, ra, rb, MUL_LAT, {32'd0, ra} * {32'd0, rb}, -1, "multu_rnd");
    end

`ifdef MD_MADD_EN
    move_to(MD_MTHI, 32'd0, "madd_hi", 32'd0, LO);
    move_to(MD_MTLO, 32'hFFFFFFFF, "madd_lo", 32'd0, 32'hFFFFFFFF);
    run_op(MD_MADDU, 32'd1, 32'd1, MUL_LAT, {32'd1, 32'd0}, -1, "maddu");
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
